// File: rtl/fib_seq_ctrl.sv
// Clear/load/run sequencer for the Fibonacci calc datapath with a start/done handshake.
// Optional wrap detection is enabled by defining FIB_SEQ_CTRL_OVF_EN.
module fib_seq_ctrl #(
    parameter int W  = 20,
    parameter int NW = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [NW-1:0] n,
    output logic          ready,
    output logic          busy,
    output logic          done,
    output logic [W-1:0]  value,
    output logic          ovf,
    output logic          dp_mux,
    output logic          dp_en,
    output logic          dp_rst_ctl,
    input  logic [W-1:0]  dp_result
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LOAD,
        S_RUN,
        S_CAP
    } state_t;

    localparam logic [NW-1:0] ONE = NW'(1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [NW-1:0] r_n;
    logic [NW-1:0] r_cnt;
    logic [W-1:0]  r_value;
    logic          r_done;
    logic          r_mux;
    logic          r_en;
    logic          r_rst_ctl;
    logic          w_accept;
    logic          w_wrap;
    logic          w_mux_nxt;
    logic          w_en_nxt;
    logic          w_rst_ctl_nxt;

`ifdef FIB_SEQ_CTRL_OVF_EN
    logic [W-1:0]  r_prev;
    logic          r_ovf;
`endif

    assign w_accept = (r_state == S_IDLE) && start;

    always_comb begin
        w_state_nxt = r_state;
        w_wrap      = 1'b0;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_CLEAR;
            S_CLEAR: w_state_nxt = (r_n == '0) ? S_CAP : S_LOAD;
            S_LOAD:  w_state_nxt = (r_n == ONE) ? S_CAP : S_RUN;
            S_RUN:   w_state_nxt = (r_cnt == ONE) ? S_CAP : S_RUN;
            S_CAP:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
`ifdef FIB_SEQ_CTRL_OVF_EN
        // A shrinking result means the sum wrapped; abort straight back to IDLE.
        if (((r_state == S_RUN) || (r_state == S_CAP)) && (dp_result < r_prev)) begin
            w_wrap      = 1'b1;
            w_state_nxt = S_IDLE;
        end
`endif
        // Controls are decoded from the next state so each flop mirrors the state it enters.
        w_rst_ctl_nxt = (w_state_nxt == S_CLEAR);
        w_mux_nxt     = (w_state_nxt == S_LOAD);
        w_en_nxt      = (w_state_nxt == S_LOAD) || (w_state_nxt == S_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_n       <= '0;
            r_cnt     <= '0;
            r_value   <= '0;
            r_done    <= 1'b0;
            r_mux     <= 1'b0;
            r_en      <= 1'b0;
            r_rst_ctl <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_mux     <= w_mux_nxt;
            r_en      <= w_en_nxt;
            r_rst_ctl <= w_rst_ctl_nxt;
            r_done    <= 1'b0;
            if (w_accept) begin
                r_n <= n;
            end
            if (r_state == S_LOAD) begin
                r_cnt <= r_n - ONE;
            end else if (r_state == S_RUN) begin
                r_cnt <= r_cnt - ONE;
            end
            if (w_wrap) begin
                r_value <= '1;
                r_done  <= 1'b1;
            end else if (r_state == S_CAP) begin
                r_value <= dp_result;
                r_done  <= 1'b1;
            end
        end
    end

`ifdef FIB_SEQ_CTRL_OVF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= '0;
            r_ovf  <= 1'b0;
        end else begin
            // prev restarts at zero per request so a stale history cannot fake a wrap.
            if (w_accept) begin
                r_prev <= '0;
                r_ovf  <= 1'b0;
            end else if ((r_state == S_LOAD) || (r_state == S_RUN)) begin
                r_prev <= dp_result;
            end
            if (w_wrap) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign ovf = r_ovf;
`else
    assign ovf = 1'b0;
`endif

    assign ready      = (r_state == S_IDLE);
    assign busy       = ~ready;
    assign done       = r_done;
    assign value      = r_value;
    assign dp_mux     = r_mux;
    assign dp_en      = r_en;
    assign dp_rst_ctl = r_rst_ctl;

endmodule

// File: tb/tb_fib_seq_ctrl.sv
// Directed bench for fib_seq_ctrl driving a behavioural calc datapath model.
// Expectations follow FIB_SEQ_CTRL_OVF_EN when it is defined for the build.
module tb_fib_seq_ctrl;

    localparam int W  = 20;
    localparam int NW = 6;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [NW-1:0] n;
    logic          ready;
    logic          busy;
    logic          done;
    logic [W-1:0]  value;
    logic          ovf;
    logic          dp_mux;
    logic          dp_en;
    logic          dp_rst_ctl;
    logic [W-1:0]  dp_result;

    logic [W-1:0]  m_fn1;
    logic [W-1:0]  m_fn2;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int cnt_rst, cnt_mux, cnt_en;
    int first_rst, first_mux, first_en;

    always #5 clk = ~clk;

    fib_seq_ctrl #(.W(W), .NW(NW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .n          (n),
        .ready      (ready),
        .busy       (busy),
        .done       (done),
        .value      (value),
        .ovf        (ovf),
        .dp_mux     (dp_mux),
        .dp_en      (dp_en),
        .dp_rst_ctl (dp_rst_ctl),
        .dp_result  (dp_result)
    );

    // Datapath: load gives (1,0); each step gives (Fn2, Fn1+Fn2), so k steps yield F(k+1).
    assign dp_result = m_fn1 + m_fn2;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_fn1 <= '0;
            m_fn2 <= '0;
        end else if (dp_rst_ctl) begin
            m_fn1 <= '0;
            m_fn2 <= '0;
        end else if (dp_en) begin
            if (dp_mux) begin
                m_fn1 <= W'(1);
                m_fn2 <= '0;
            end else begin
                m_fn1 <= m_fn2;
                m_fn2 <= m_fn1 + m_fn2;
            end
        end
    end

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (dp_rst_ctl) begin
            if (cnt_rst == 0) first_rst = cyc;
            cnt_rst = cnt_rst + 1;
        end
        if (dp_mux) begin
            if (cnt_mux == 0) first_mux = cyc;
            cnt_mux = cnt_mux + 1;
        end
        if (dp_en) begin
            if (cnt_en == 0) first_en = cyc;
            cnt_en = cnt_en + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Returns the edge offset (from the current accept edge) at which done is seen, or 999.
    task automatic wait_done(output int lat);
        bit seen;
        seen = 1'b0;
        lat  = 999;
        for (int k = 1; k <= 100 && !seen; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                seen = 1'b1;
                lat  = k;
            end
        end
    endtask

    task automatic run_req(input logic [NW-1:0] nn, input logic [W-1:0] ev, input logic eo,
                           input int elat, input bit hold, input string tag);
        int lat;
        @(negedge clk);
        start = 1'b1;
        n     = nn;
        @(posedge clk);
        #1;
        cnt_rst = 0; cnt_mux = 0; cnt_en = 0;
        first_rst = 0; first_mux = 0; first_en = 0;
        if (hold) begin
            n = NW'(3);
        end else begin
            start = 1'b0;
            n     = ~nn;
        end
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_ovf_clr"}, ovf, 0);
        wait_done(lat);
        chk({tag, "_lat"}, lat, elat);
        chk({tag, "_value"}, value, ev);
        chk({tag, "_ovf"}, ovf, eo);
        chk({tag, "_ready"}, ready, 1);
        if (!hold) begin
            @(posedge clk);
            #1;
            chk({tag, "_pulse"}, done, 0);
            chk({tag, "_hold"}, value, ev);
        end
    endtask

    initial begin
        int lat;
        int dseen;
        cnt_rst = 0; cnt_mux = 0; cnt_en = 0;
        first_rst = 0; first_mux = 0; first_en = 0;
        rst_n = 1'b0;
        start = 1'b0;
        n     = '0;
        #2;
        chk("rst_ready", ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_value", value, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_dp", {dp_mux, dp_en, dp_rst_ctl}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_req(6'd10, 20'd55, 1'b0, 12, 1'b0, "n10");
        chk("n10_rst_cycles", cnt_rst, 1);
        chk("n10_mux_cycles", cnt_mux, 1);
        chk("n10_en_cycles", cnt_en, 10);
        chk("n10_order_mux", first_mux - first_rst, 1);
        chk("n10_order_en", first_en - first_mux, 0);

        run_req(6'd0, 20'd0, 1'b0, 2, 1'b0, "n0");
        run_req(6'd1, 20'd1, 1'b0, 3, 1'b0, "n1");
        run_req(6'd30, 20'd832040, 1'b0, 32, 1'b0, "n30");
`ifdef FIB_SEQ_CTRL_OVF_EN
        run_req(6'd31, 20'hFFFFF, 1'b1, 33, 1'b0, "n31");
        run_req(6'd40, 20'hFFFFF, 1'b1, 33, 1'b0, "n40");
`else
        run_req(6'd31, 20'd297693, 1'b0, 33, 1'b0, "n31");
        run_req(6'd40, 20'd622283, 1'b0, 42, 1'b0, "n40");
`endif
        run_req(6'd5, 20'd5, 1'b0, 7, 1'b0, "n5");

        // start held high throughout an n=10 run; it must be taken again only in the done cycle
        run_req(6'd10, 20'd55, 1'b0, 12, 1'b1, "busy_start");
        @(posedge clk);
        #1;
        chk("done_cycle_accept", busy, 1);
        chk("done_cycle_pulse", done, 0);
        start = 1'b0;
        wait_done(lat);
        chk("n3_lat", lat, 5);
        chk("n3_value", value, 2);

        @(negedge clk);
        start = 1'b1;
        n     = 6'd20;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("abort_in_run", dp_en, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_ready", ready, 1);
        chk("abort_value", value, 0);
        chk("abort_done", done, 0);
        chk("abort_dp", {dp_mux, dp_en, dp_rst_ctl}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        dseen = 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (done) dseen = dseen + 1;
        end
        chk("abort_no_done", dseen, 0);
        run_req(6'd20, 20'd6765, 1'b0, 22, 1'b0, "n20");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
